// File: rtl/axi_ic_pkg.sv
// ---------------------------------------------------------------------------
// axi_ic_pkg
// Shared definitions for the 2-slave AXI interconnect: read-router state
// encoding, the slave-1 address window size used by the decoder, AXI response
// and burst-type codes, and a saturating counter helper.
// ---------------------------------------------------------------------------
package axi_ic_pkg;

    // Read-router FSM states
    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_ADDR = 2'd1,
        RD_DATA = 2'd2
    } rd_state_e;

    // Slave 1 owns [0, S1_WIDTH); slave 2 owns the rest
    localparam logic [31:0] S1_WIDTH = 32'h8000_0000;

    // AXI response codes
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // AXI burst types
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // 8-bit increment that sticks at 255 instead of wrapping
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_beat_checker.sv
// ---------------------------------------------------------------------------
// axi_beat_checker
// Counts data beats of one burst and raises a sticky protocol-error flag when
// the LAST marker does not line up with the requested burst length.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_clear       restart the beat count (new burst accepted)
//   i_beat        one data-beat handshake this cycle
//   i_last        LAST marker of that beat
//   i_len         burst length minus 1 of the burst in flight
//   o_proto_err   sticky: early LAST or missing LAST seen since reset
// ---------------------------------------------------------------------------
module axi_beat_checker
    import axi_ic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_beat,
    input  logic       i_last,
    input  logic [7:0] i_len,
    output logic       o_proto_err
);

    logic [7:0] r_count;
    logic       r_proto_err;
    logic       w_early_last;
    logic       w_missing_last;

    // r_count holds the index of the beat currently being transferred
    // Classify the current beat against the expected last index
    always_comb begin
        w_early_last   = 1'b0;
        w_missing_last = 1'b0;
        if (i_beat) begin
            w_early_last   = i_last & (r_count != i_len);
            w_missing_last = ~i_last & (r_count == i_len);
        end else begin
            w_early_last   = 1'b0;
            w_missing_last = 1'b0;
        end
    end

    // Beat counter (saturating) and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= 8'd0;
            r_proto_err <= 1'b0;
        end else begin
            if (i_clear) begin
                r_count <= 8'd0;
            end else if (i_beat) begin
                r_count <= sat_inc8(r_count);
            end else begin
                r_count <= r_count;
            end
            if (w_early_last || w_missing_last) begin
                r_proto_err <= 1'b1;
            end else begin
                r_proto_err <= r_proto_err;
            end
        end
    end

    assign o_proto_err = r_proto_err;

endmodule

// File: rtl/axi_rd_router.sv
// ---------------------------------------------------------------------------
// axi_rd_router
// Read-channel router for the 2-slave AXI interconnect. Accepts one AR from
// the master together with the decoder's slave select and translated
// addresses, issues the AR to the selected slave, then passes that slave's
// R beats back to the master until RLAST. One transaction at a time.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   m_ar*                    master AR channel (valid/ready/len/size/burst)
//   rd_slave1_sel            decoder: 1 = slave 1, 0 = slave 2
//   s1_rd_addr, s2_rd_addr   decoder: slave-local addresses
//   sN_ar*                   slave AR channels
//   sN_r*                    slave R channels
//   m_r*                     master R channel
//   proto_err                sticky burst-length violation flag
// ---------------------------------------------------------------------------
module axi_rd_router
    import axi_ic_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // master AR
    input  logic                  m_arvalid,
    output logic                  m_arready,
    input  logic [7:0]            m_arlen,
    input  logic [2:0]            m_arsize,
    input  logic [1:0]            m_arburst,
    // decoder
    input  logic                  rd_slave1_sel,
    input  logic [ADDR_WIDTH-1:0] s1_rd_addr,
    input  logic [ADDR_WIDTH-1:0] s2_rd_addr,
    // slave 1
    output logic [ADDR_WIDTH-1:0] s1_araddr,
    output logic [7:0]            s1_arlen,
    output logic [2:0]            s1_arsize,
    output logic [1:0]            s1_arburst,
    output logic                  s1_arvalid,
    input  logic                  s1_arready,
    input  logic [DATA_WIDTH-1:0] s1_rdata,
    input  logic [1:0]            s1_rresp,
    input  logic                  s1_rlast,
    input  logic                  s1_rvalid,
    output logic                  s1_rready,
    // slave 2
    output logic [ADDR_WIDTH-1:0] s2_araddr,
    output logic [7:0]            s2_arlen,
    output logic [2:0]            s2_arsize,
    output logic [1:0]            s2_arburst,
    output logic                  s2_arvalid,
    input  logic                  s2_arready,
    input  logic [DATA_WIDTH-1:0] s2_rdata,
    input  logic [1:0]            s2_rresp,
    input  logic                  s2_rlast,
    input  logic                  s2_rvalid,
    output logic                  s2_rready,
    // master R
    output logic [DATA_WIDTH-1:0] m_rdata,
    output logic [1:0]            m_rresp,
    output logic                  m_rlast,
    output logic                  m_rvalid,
    input  logic                  m_rready,
    output logic                  proto_err
);

    rd_state_e             r_state;
    rd_state_e             w_next_state;
    logic                  r_sel;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;

    logic                  w_ar_hs;
    logic                  w_sel_arready;
    logic                  w_sel_rvalid;
    logic                  w_sel_rlast;
    logic                  w_beat;

    // Handshake and selected-slave qualifiers; r_sel picks the slave so that
    // decoder changes after acceptance cannot redirect the burst
    always_comb begin
        w_ar_hs       = (r_state == RD_IDLE) & m_arvalid;
        w_sel_arready = r_sel ? s1_arready : s2_arready;
        w_sel_rvalid  = r_sel ? s1_rvalid  : s2_rvalid;
        w_sel_rlast   = r_sel ? s1_rlast   : s2_rlast;
        w_beat        = (r_state == RD_DATA) & w_sel_rvalid & m_rready;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RD_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RD_IDLE: begin
                if (m_arvalid) begin
                    w_next_state = RD_ADDR;
                end else begin
                    w_next_state = RD_IDLE;
                end
            end
            RD_ADDR: begin
                if (w_sel_arready) begin
                    w_next_state = RD_DATA;
                end else begin
                    w_next_state = RD_ADDR;
                end
            end
            RD_DATA: begin
                if (w_beat && w_sel_rlast) begin
                    w_next_state = RD_IDLE;
                end else begin
                    w_next_state = RD_DATA;
                end
            end
            default: begin
                w_next_state = RD_IDLE;
            end
        endcase
    end

    // Capture the AR request and slave select when the master handshake occurs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel   <= 1'b0;
            r_addr  <= '0;
            r_len   <= 8'd0;
            r_size  <= 3'd0;
            r_burst <= 2'd0;
        end else if (w_ar_hs) begin
            r_sel   <= rd_slave1_sel;
            r_addr  <= rd_slave1_sel ? s1_rd_addr : s2_rd_addr;
            r_len   <= m_arlen;
            r_size  <= m_arsize;
            r_burst <= m_arburst;
        end else begin
            r_sel   <= r_sel;
            r_addr  <= r_addr;
            r_len   <= r_len;
            r_size  <= r_size;
            r_burst <= r_burst;
        end
    end

    // Output steering: AR to the selected slave, R pass-through in DATA only
    always_comb begin
        m_arready  = 1'b0;
        s1_arvalid = 1'b0;
        s2_arvalid = 1'b0;
        s1_rready  = 1'b0;
        s2_rready  = 1'b0;
        m_rvalid   = 1'b0;
        m_rdata    = '0;
        m_rresp    = 2'b00;
        m_rlast    = 1'b0;
        s1_araddr  = '0;
        s1_arlen   = 8'd0;
        s1_arsize  = 3'd0;
        s1_arburst = 2'd0;
        s2_araddr  = '0;
        s2_arlen   = 8'd0;
        s2_arsize  = 3'd0;
        s2_arburst = 2'd0;
        // The unselected slave always sees all-zero AR fields
        if (r_sel) begin
            s1_araddr  = r_addr;
            s1_arlen   = r_len;
            s1_arsize  = r_size;
            s1_arburst = r_burst;
        end else begin
            s2_araddr  = r_addr;
            s2_arlen   = r_len;
            s2_arsize  = r_size;
            s2_arburst = r_burst;
        end
        case (r_state)
            RD_IDLE: begin
                m_arready = 1'b1;
            end
            RD_ADDR: begin
                if (r_sel) begin
                    s1_arvalid = 1'b1;
                end else begin
                    s2_arvalid = 1'b1;
                end
            end
            RD_DATA: begin
                if (r_sel) begin
                    m_rdata   = s1_rdata;
                    m_rresp   = s1_rresp;
                    m_rlast   = s1_rlast;
                    m_rvalid  = s1_rvalid;
                    s1_rready = m_rready;
                end else begin
                    m_rdata   = s2_rdata;
                    m_rresp   = s2_rresp;
                    m_rlast   = s2_rlast;
                    m_rvalid  = s2_rvalid;
                    s2_rready = m_rready;
                end
            end
            default: begin
                m_arready = 1'b0;
            end
        endcase
    end

    axi_beat_checker u_beat_checker (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_ar_hs),
        .i_beat      (w_beat),
        .i_last      (w_sel_rlast),
        .i_len       (r_len),
        .o_proto_err (proto_err)
    );

endmodule

// File: doc/axi_rd_router.md
Name: axi_rd_router

Overview:
- Read-channel router of the 2-slave AXI interconnect, directly downstream of the address decoder.
- Accepts one AR request from the master and takes the decoder's slave select and translated address.
- Issues the AR to the selected slave and steers that slave's R beats back to the master until RLAST.
- Single outstanding read transaction; a burst-length checker flags RLAST protocol violations.

Parameters:
- DATA_WIDTH, 32, width of RDATA on master and slave sides
- ADDR_WIDTH, 32, width of ARADDR and of the decoder address inputs

Ports:
- clk  in  1  interconnect clock
- rst  in  1  synchronous active-high reset
- m_arvalid  in  1  master AR valid
- m_arready  out  1  master AR ready
- m_arlen  in  8  burst length minus 1
- m_arsize  in  3  beat size
- m_arburst  in  2  burst type
- rd_slave1_sel  in  1  decoder: address below 0x8000_0000
- s1_rd_addr  in  ADDR_WIDTH  decoder: slave-1 local address
- s2_rd_addr  in  ADDR_WIDTH  decoder: slave-2 local address (address minus 0x8000_0000)
- sN_araddr, sN_arlen, sN_arsize, sN_arburst  out  ADDR_WIDTH/8/3/2  slave AR fields (N=1,2)
- sN_arvalid  out  1  slave AR valid
- sN_arready  in  1  slave AR ready
- sN_rdata  in  DATA_WIDTH  slave R data
- sN_rresp  in  2  slave R response
- sN_rlast  in  1  slave R last
- sN_rvalid  in  1  slave R valid
- sN_rready  out  1  slave R ready
- m_rdata  out  DATA_WIDTH  master R data
- m_rresp  out  2  master R response
- m_rlast  out  1  master R last
- m_rvalid  out  1  master R valid
- m_rready  in  1  master R ready
- proto_err  out  1  sticky burst-length violation flag

Behaviour:
- Clock and reset: one clock clk; rst is synchronous and active-high.
- Reset values: state=IDLE; m_arready=1 (IDLE); sN_arvalid=0; sN_rready=0; m_rvalid=0; proto_err=0; beat counter=0; captured AR registers=0.
- Reset mid-operation: same as above on the next edge; any in-flight burst is abandoned and no response is replayed.
- FSM IDLE:
  - m_arready=1, independent of m_arvalid.
  - On m_arvalid&m_arready, register sel=rd_slave1_sel, the selected translated address, arlen/arsize/arburst, and clear the beat counter.
  - Next state ADDR.
- FSM ADDR:
  - m_arready=0.
  - Selected slave's arvalid=1 with the registered fields; the other slave's arvalid=0 and its fields hold 0.
  - Stays in ADDR until the selected sN_arready=1 (arvalid held stable; AXI rule).
  - On handshake, next state DATA.
  - Latency: the master AR handshake at edge N gives sN_arvalid high in cycle N+1.
- FSM DATA:
  - Combinational pass-through: m_rdata/m_rresp/m_rlast/m_rvalid come from the selected slave; selected sN_rready=m_rready; unselected sN_rready=0.
  - The unselected slave's R signals are ignored.
  - Each beat handshake (m_rvalid&m_rready) increments the 8-bit beat counter.
  - A beat with rlast=1 returns the FSM to IDLE on that edge; a new AR can be accepted the following cycle.
- proto_err is set (sticky until rst) on either condition:
  - a beat with rlast=1 arrives while counter!=arlen (early last);
  - a beat with rlast=0 arrives while counter==arlen (missing last).
- After a missing last the router keeps forwarding until rlast arrives. The counter saturates at 255 and never wraps.
- Outside DATA: m_rvalid=0, m_rlast=0, m_rdata=0, m_rresp=0.
- The slave select is registered at AR acceptance; later changes on the decoder inputs have no effect on the burst in flight.
- Back-pressure: m_rready=0 stalls the selected slave via rready, and no beat is lost or duplicated.

Decomposition:
- Shared package (axi_ic_pkg):
  - state encoding constants RD_IDLE, RD_ADDR, RD_DATA;
  - S1_WIDTH=32'h8000_0000, shared with the decoder;
  - AXI resp codes OKAY=2'b00, SLVERR=2'b10;
  - burst type constants.
- One natural sub-module: axi_beat_checker (counter plus proto_err logic), reusable by the write-data router.

Test Plan:
- AR at 0x0000_1000, arlen=0, s1 returns one beat 0xDEADBEEF rlast=1 -> s1_araddr=0x0000_1000 one cycle after AR handshake; m_rdata=0xDEADBEEF, m_rlast=1; s2_arvalid never asserted; FSM back to IDLE; proto_err=0.
- AR at 0x8000_0040, arlen=3 -> s2_araddr=0x0000_0040, s2_arlen=3; 4 beats forwarded in order, rlast only on the 4th; s1_rready stays 0.
- Same burst with m_rready toggling 1,0,0,1 per cycle and s2_arready delayed 5 cycles -> s2_arvalid held 5 cycles with stable fields; all 4 beats delivered exactly once.
- arlen=3, slave asserts rlast on beat 2 -> proto_err=1 from the next cycle, FSM returns to IDLE; proto_err stays 1 through a following clean burst until rst.
- arlen=1, slave omits rlast on beat 2 and sends it on beat 3 -> proto_err=1; 3 beats forwarded; IDLE after beat 3.
- rst=1 asserted during DATA after beat 1 of 4 -> next cycle m_arready=1, sN_rready=0, m_rvalid=0, proto_err=0; a new AR to 0x7FFF_FFFC routes to s1.
